// File: rtl/rename_dispatch_ctrl.sv
// Purpose : rename/dispatch allocation; picks the in-order dispatch prefix of the
//           decode bundle and hands each dest-writing slot its own free preg.
// Latency : zero-cycle allocation (combinational); FSM/counters update on clock.
// Backpr. : dispatch is held by ROB/RS/free-list capacity, by squash and for
//           RECOVER_CYCLES cycles after it; the free list pops dispatch_num next edge.
//
// Ports:
//   clock, reset                 : rising-edge clock, async active-high reset
//   inst_valid/inst_has_dest     : per-slot decode info, slot 0 oldest
//   free_list_out/free_num       : offered free pregs (entry 0 first) and how many
//   rob_free_num/rs_free_num     : downstream capacity, saturated at N_WAY
//   squash                       : flush; starts the recovery window
//   dispatch_valid/count/num     : dispatching slots, their count, pregs consumed
//   slot_preg                    : preg assigned per slot (0 when none)
//   ctrl_state/starve_cycles     : 0 RUN, 1 STARVED, 2 RECOVER; saturating starve count

`ifndef N_WAY
`define N_WAY 3
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

module rename_dispatch_ctrl #(
  parameter int N_WAY          = `N_WAY,
  parameter int CDB_BITS       = `CDB_BITS,
  parameter int RECOVER_CYCLES = 2,
  localparam int CW            = $clog2(N_WAY) + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_WAY-1:0]          inst_valid,
  input  logic [N_WAY-1:0]          inst_has_dest,
  input  logic [N_WAY*CDB_BITS-1:0] free_list_out,
  input  logic [CW-1:0]             free_num,
  input  logic [CW-1:0]             rob_free_num,
  input  logic [CW-1:0]             rs_free_num,
  input  logic                      squash,
  output logic [N_WAY-1:0]          dispatch_valid,
  output logic [CW-1:0]             dispatch_count,
  output logic [CW-1:0]             dispatch_num,
  output logic [N_WAY*CDB_BITS-1:0] slot_preg,
  output logic [1:0]                ctrl_state,
  output logic [15:0]               starve_cycles
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STARVED = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [15:0] starve_q, starve_d;

  // Allocation scan results before squash/recover gating.
  logic [N_WAY-1:0]          alloc_valid;
  logic [N_WAY*CDB_BITS-1:0] alloc_preg;
  int                        alloc_cnt;
  int                        alloc_dest;
  int                        need_dest;
  logic                      starve_block;
  logic                      scan_ok;
  logic                      rob_ok;
  logic                      rs_ok;
  logic                      preg_ok;
  logic                      hold;

  always_comb begin
    alloc_valid  = '0;
    alloc_preg   = '0;
    alloc_cnt    = 0;
    alloc_dest   = 0;
    need_dest    = 0;
    starve_block = 1'b0;
    scan_ok      = 1'b1;
    rob_ok       = 1'b0;
    rs_ok        = 1'b0;
    preg_ok      = 1'b0;
    for (int i = 0; i < N_WAY; i++) begin
      need_dest = alloc_dest + (inst_has_dest[i] ? 1 : 0);
      rob_ok    = (i + 1) <= int'(rob_free_num);
      rs_ok     = (i + 1) <= int'(rs_free_num);
      preg_ok   = need_dest <= int'(free_num);
      if (scan_ok) begin
        if (inst_valid[i] && rob_ok && rs_ok && preg_ok) begin
          alloc_valid[i] = 1'b1;
          alloc_cnt      = alloc_cnt + 1;
          if (inst_has_dest[i]) begin
            // alloc_dest counts older dispatched dest slots = free-list index.
            alloc_preg[i*CDB_BITS +: CDB_BITS] = free_list_out[alloc_dest*CDB_BITS +: CDB_BITS];
            alloc_dest = need_dest;
          end
        end else begin
          // First stalled slot: starvation only if the free list alone blocks it.
          starve_block = inst_valid[i] && rob_ok && rs_ok;
          scan_ok      = 1'b0;
        end
      end
    end
  end

  // Reset is included directly so outputs drop while it is high, not just after.
  assign hold = reset || squash || (state_q == ST_RECOVER);

  assign dispatch_valid = hold ? '0 : alloc_valid;
  assign dispatch_count = hold ? '0 : CW'(alloc_cnt);
  assign dispatch_num   = hold ? '0 : CW'(alloc_dest);
  assign slot_preg      = hold ? '0 : alloc_preg;
  assign ctrl_state     = state_q;
  assign starve_cycles  = starve_q;

  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    starve_d = starve_q;
    if (state_q == ST_STARVED && starve_q != 16'hFFFF) begin
      starve_d = starve_q + 16'd1;
    end
    if (squash) begin
      state_d = ST_RECOVER;
      rcnt_d  = 4'(RECOVER_CYCLES);
    end else begin
      case (state_q)
        ST_RUN: begin
          if (starve_block) state_d = ST_STARVED;
        end
        ST_STARVED: begin
          if (!starve_block) state_d = ST_RUN;
        end
        ST_RECOVER: begin
          // Counter reading 1 is the last blocked cycle.
          if (rcnt_q <= 4'd1) begin
            state_d = ST_RUN;
            rcnt_d  = 4'd0;
          end else begin
            rcnt_d = rcnt_q - 4'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      rcnt_q   <= 4'd0;
      starve_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: doc/rename_dispatch_ctrl.md
# rename_dispatch_ctrl

Dispatch/rename allocation controller that sits between the decode bundle and the physical-register free list of the N-way core. Each cycle it decides how many instructions of the in-order bundle may dispatch, given free physical registers, ROB space and RS space. It hands each destination-writing instruction its own free-list entry and drives the free list's `dispatch_num` (allocation count). A small FSM tracks free-list starvation and holds dispatch for a fixed window after a squash while the free list is being restored.

## Interface
- `N_WAY`, default `` `N_WAY `` (3): bundle width.
- `CDB_BITS`, default `` `CDB_BITS `` (6): physical register tag width.
- `RECOVER_CYCLES`, default 2: dispatch-blocked cycles after a squash (1..15).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `inst_valid` in N_WAY: decoded slot valid; slot 0 is oldest.
- `inst_has_dest` in N_WAY: slot writes a destination register and needs a preg.
- `free_list_out` in N_WAY×CDB_BITS: free pregs from the free list; entry 0 is allocated first.
- `free_num` in clog2(N_WAY)+1: number of valid `free_list_out` entries.
- `rob_free_num` in clog2(N_WAY)+1: ROB entries available this cycle, saturated at N_WAY.
- `rs_free_num` in clog2(N_WAY)+1: RS entries available, saturated at N_WAY.
- `squash` in 1: mispredict/exception flush.
- `dispatch_valid` out N_WAY: slot dispatches this cycle.
- `dispatch_count` out clog2(N_WAY)+1: popcount of `dispatch_valid`.
- `dispatch_num` out clog2(N_WAY)+1: pregs consumed; connects to free-list `dispatch_num`.
- `slot_preg` out N_WAY×CDB_BITS: assigned preg per slot; 0 if no dest or not dispatched.
- `ctrl_state` out 2: 0 RUN, 1 STARVED, 2 RECOVER.
- `starve_cycles` out 16: saturating count of cycles spent in STARVED.

## Operation
- Allocation is combinational from the current inputs and the registered state.
- Scan slots 0..N_WAY-1 in order. Slot i dispatches iff all of the following hold:
  - `inst_valid[i]`;
  - every older slot dispatched;
  - (i+1) ≤ `rob_free_num`;
  - (i+1) ≤ `rs_free_num`;
  - (dest count over slots 0..i) ≤ `free_num`.
- The first failing slot stops the scan; no younger slot dispatches (no skipping of invalid holes).
- `slot_preg[i]` = `free_list_out[k]`, where k = number of has_dest slots older than i that dispatched.
- `dispatch_num` = number of dispatched slots with `inst_has_dest`.
- Force all of `dispatch_valid`, `dispatch_count`, `dispatch_num` and `slot_preg` to 0 when any of these holds: `reset`, `squash`, or `ctrl_state`==RECOVER.
- FSM, priority order:
  - `squash` in any state → RECOVER; load counter = RECOVER_CYCLES.
  - RECOVER: decrement the counter each cycle; when it reads 1, go to RUN next.
  - RUN → STARVED when the first non-dispatching valid slot is blocked only by the preg condition (ROB/RS would allow it).
  - STARVED → RUN when that condition clears. STARVED still dispatches whatever is legal.
- `starve_cycles` increments every cycle `ctrl_state`==STARVED and saturates at 0xFFFF. It is cleared only by reset.

## Timing
- Reset values:
  - `ctrl_state`=RUN.
  - RECOVER counter = 0.
  - `starve_cycles` = 0.
  - All dispatch outputs = 0.
- Zero-latency allocation: outputs are valid in the same cycle as the inputs. The free list consumes `dispatch_num` at the next rising edge.
- Exactly RECOVER_CYCLES cycles with zero dispatch follow the squash cycle; the squash cycle itself also dispatches nothing.
- Squash during RECOVER reloads the counter (window restarts).
- `free_num`=0 with a has_dest instruction in slot 0 means dispatch of that slot = 0. The slot is still blocked even if younger slots have no dest.
- `reset` asserted mid-operation: state and counters clear immediately (async); outputs are 0 while it is high.

## Test plan
- Parameters for all scenarios: N_WAY=3, CDB_BITS=6, RECOVER_CYCLES=2. Free list offers {32,33,34}, free_num=3, rob/rs=3.
- Full dispatch: valid=111, dest=111 → valid=111, dispatch_num=3, slot_preg={32,33,34}, state RUN.
- Mixed dest: valid=111, dest=101 → dispatch_num=2, slot_preg[0]=32, slot_preg[1]=0, slot_preg[2]=33.
- Preg starvation: free_num=1, dest=111 → valid=001, dispatch_num=1. Next cycle state=STARVED and starve_cycles counts 1,2,... Restoring free_num=3 → RUN.
- ROB limit: rob_free_num=2, free_num=3, dest=111 → valid=011; state stays RUN because ROB, not the free list, is the blocker.
- Squash: assert squash one cycle during full dispatch → outputs 0 that cycle plus 2 more, then valid=111. A second squash in cycle 1 of RECOVER extends the window to 2 cycles after it.
- Async reset mid-STARVED: starve_cycles → 0 and state → RUN without a clock edge; outputs are 0 while reset is high.
